// File: rtl/ac_pkg.sv
// Shared definitions for the access_control sequencer: FSM state encoding and
// register-file word indices.
package ac_pkg;

  typedef logic [2:0] ac_state_t;

  localparam ac_state_t StIdle   = 3'd0;
  localparam ac_state_t StClrEnd = 3'd1;
  localparam ac_state_t StClrSt  = 3'd2;
  localparam ac_state_t StRun    = 3'd3;
  localparam ac_state_t StDone   = 3'd4;

  localparam int unsigned CRF_IDX_UPSTR   = 0;
  localparam int unsigned CRF_IDX_UPENDR  = 1;
  localparam int unsigned CRF_IDX_UPSRCAR = 2;
  localparam int unsigned CRF_IDX_UPDSTAR = 3;

  localparam int unsigned UPSTR_START_BIT = 0;

endpackage

// File: rtl/ac_cmd_gen.sv
// Burst command stream generator: issues COUNT commands at base + idx*BURST_BYTES
// over a registered valid/ready handshake while enabled.
module ac_cmd_gen #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BURST_BYTES = 256,
  parameter int unsigned COUNT       = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  all_acc_o
);

  localparam int unsigned CntW    = $clog2(COUNT + 1);
  localparam int unsigned BurstLg = $clog2(BURST_BYTES);
  localparam logic [CntW-1:0] CountC = CntW'(COUNT);

  logic [CntW-1:0]       idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] off;

  // Next index/valid/address; address recomputed from idx so a stall leaves it unchanged.
  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    off     = '0;
    if (clear_i) begin
      idx_d   = '0;
      valid_d = 1'b0;
    end else if (en_i) begin
      if (valid_q && ready_i) begin
        idx_d = idx_q + CntW'(1);
      end
      valid_d = (idx_d < CountC);
      off     = ADDR_WIDTH'(idx_d) << BurstLg;
      if (valid_d) begin
        addr_d = base_i + off;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Stream state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o   = valid_q;
  assign addr_o    = addr_q;
  assign all_acc_o = (idx_q == CountC);

endmodule

// File: rtl/access_control.sv
// PL-side frame sequencer: takes a start request from the config register file,
// clears the status registers, streams read/write DMA burst commands, waits for all
// write completions, then flags completion through UPENDR.
module access_control
  import ac_pkg::*;
#(
  parameter int unsigned CRF_DATA_WIDTH = 32,
  parameter int unsigned CRF_ADDR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned BURST_BYTES    = 256,
  parameter int unsigned SRC_BYTES      = 2073600,
  parameter int unsigned DST_BYTES      = 33177600
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSTR,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPENDR,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSRCAR,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPDSTAR,
  input  logic                      crf_ac_wbusy,
  output logic                      ac_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
  output logic                      rd_cmd_valid,
  input  logic                      rd_cmd_ready,
  output logic [ADDR_WIDTH-1:0]     rd_cmd_addr,
  output logic                      wr_cmd_valid,
  input  logic                      wr_cmd_ready,
  output logic [ADDR_WIDTH-1:0]     wr_cmd_addr,
  input  logic                      wr_done,
  output logic                      ac_busy
);

  localparam int unsigned NRD   = SRC_BYTES / BURST_BYTES;
  localparam int unsigned NWR   = DST_BYTES / BURST_BYTES;
  localparam int unsigned DoneW = $clog2(NWR + 1);
  localparam int unsigned MaxW  = (ADDR_WIDTH > CRF_DATA_WIDTH) ? ADDR_WIDTH : CRF_DATA_WIDTH;
  localparam logic [DoneW-1:0] NwrC = DoneW'(NWR);

  // Truncate or zero-extend a register value to a DMA byte address.
  function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [CRF_DATA_WIDTH-1:0] d);
    logic [MaxW-1:0] t;
    t = MaxW'(d);
    return t[ADDR_WIDTH-1:0];
  endfunction

  ac_state_t                 state_q, state_d;
  logic                      wrt_q, wrt_d;
  logic [CRF_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [CRF_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]     src_q, src_d, dst_q, dst_d;
  logic [DoneW-1:0]          done_cnt_q, done_cnt_d;
  logic                      gen_clear, gen_en, rd_all, wr_all, taken;

  // UPENDR is status-only here; the other UPSTR bits carry no meaning for this block.
  logic unused_inputs;
  assign unused_inputs = ^{crf_ac_UPENDR, crf_ac_UPSTR, wr_all};

  assign taken  = wrt_q & ~crf_ac_wbusy;
  assign gen_en = (state_q == StRun);

  // Sequencer next state and CRF write request.
  always_comb begin
    state_d    = state_q;
    wrt_d      = wrt_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    src_d      = src_q;
    dst_d      = dst_q;
    done_cnt_d = done_cnt_q;
    gen_clear  = 1'b0;
    case (state_q)
      StIdle: begin
        if (crf_ac_UPSTR[UPSTR_START_BIT]) begin
          src_d      = to_addr(crf_ac_UPSRCAR);
          dst_d      = to_addr(crf_ac_UPDSTAR);
          done_cnt_d = '0;
          gen_clear  = 1'b1;
          wrt_d      = 1'b1;
          waddr_d    = CRF_ADDR_WIDTH'(CRF_IDX_UPENDR);
          wdata_d    = '0;
          state_d    = StClrEnd;
        end
      end
      StClrEnd: begin
        if (taken) begin
          wrt_d   = 1'b0;
          state_d = StClrSt;
        end
      end
      StClrSt: begin
        // wrt is low for one cycle after the previous write was taken.
        if (!wrt_q) begin
          wrt_d   = 1'b1;
          waddr_d = CRF_ADDR_WIDTH'(CRF_IDX_UPSTR);
          wdata_d = '0;
        end else if (taken) begin
          wrt_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (wr_done && (done_cnt_q != NwrC)) begin
          done_cnt_d = done_cnt_q + DoneW'(1);
        end
        if ((done_cnt_q == NwrC) && rd_all) begin
          wrt_d   = 1'b1;
          waddr_d = CRF_ADDR_WIDTH'(CRF_IDX_UPENDR);
          wdata_d = CRF_DATA_WIDTH'(1);
          state_d = StDone;
        end
      end
      StDone: begin
        if (taken) begin
          wrt_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        wrt_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state, snapshots and completion counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      wrt_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wrt_q      <= wrt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  ac_cmd_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BURST_BYTES (BURST_BYTES),
    .COUNT       (NRD)
  ) u_rd_gen (
    .clk       (clk),
    .rstn      (rstn),
    .clear_i   (gen_clear),
    .en_i      (gen_en),
    .base_i    (src_q),
    .valid_o   (rd_cmd_valid),
    .ready_i   (rd_cmd_ready),
    .addr_o    (rd_cmd_addr),
    .all_acc_o (rd_all)
  );

  ac_cmd_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BURST_BYTES (BURST_BYTES),
    .COUNT       (NWR)
  ) u_wr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .clear_i   (gen_clear),
    .en_i      (gen_en),
    .base_i    (dst_q),
    .valid_o   (wr_cmd_valid),
    .ready_i   (wr_cmd_ready),
    .addr_o    (wr_cmd_addr),
    .all_acc_o (wr_all)
  );

  assign ac_crf_wrt   = wrt_q;
  assign ac_crf_waddr = waddr_q;
  assign ac_crf_wdata = wdata_q;
  assign ac_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_access_control.sv
// Scoreboard bench for access_control with a small frame (6 read, 10 write bursts).
module tb_access_control;

  localparam int unsigned BURST = 256;
  localparam int unsigned NRD   = 6;
  localparam int unsigned NWR   = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] crf [4] = '{default: 32'd0};
  logic        ps_we = 1'b0;
  logic [1:0]  ps_addr = 2'd0;
  logic [31:0] ps_data = 32'd0;
  logic        busy_force = 1'b0;
  logic        rand_mode = 1'b0;

  logic        crf_ac_wbusy;
  logic        ac_crf_wrt;
  logic [31:0] ac_crf_waddr, ac_crf_wdata;
  logic        rd_cmd_valid, wr_cmd_valid, ac_busy;
  logic        rd_cmd_ready = 1'b0;
  logic        wr_cmd_ready = 1'b0;
  logic        wr_done = 1'b0;
  logic [31:0] rd_cmd_addr, wr_cmd_addr;

  logic [31:0] rd_exp_q[$];
  logic [31:0] wr_exp_q[$];
  logic [63:0] w_exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int acc_wr = 0, done_issued = 0, run_rd = 0, run_wr = 0, run_wrd = 0, wr_taken_cnt = 0;
  logic busy_chk_pending = 1'b0;

  assign crf_ac_wbusy = ps_we | busy_force;

  access_control #(
    .CRF_DATA_WIDTH (32),
    .CRF_ADDR_WIDTH (32),
    .ADDR_WIDTH     (32),
    .BURST_BYTES    (BURST),
    .SRC_BYTES      (NRD * BURST),
    .DST_BYTES      (NWR * BURST)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .crf_ac_UPSTR   (crf[0]),
    .crf_ac_UPENDR  (crf[1]),
    .crf_ac_UPSRCAR (crf[2]),
    .crf_ac_UPDSTAR (crf[3]),
    .crf_ac_wbusy   (crf_ac_wbusy),
    .ac_crf_wrt     (ac_crf_wrt),
    .ac_crf_waddr   (ac_crf_waddr),
    .ac_crf_wdata   (ac_crf_wdata),
    .rd_cmd_valid   (rd_cmd_valid),
    .rd_cmd_ready   (rd_cmd_ready),
    .rd_cmd_addr    (rd_cmd_addr),
    .wr_cmd_valid   (wr_cmd_valid),
    .wr_cmd_ready   (wr_cmd_ready),
    .wr_cmd_addr    (wr_cmd_addr),
    .wr_done        (wr_done),
    .ac_busy        (ac_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Register file model: a PS write wins and blocks the PL write in that cycle.
  always @(posedge clk) begin
    if (ps_we) crf[ps_addr] <= ps_data;
    else if (ac_crf_wrt && !crf_ac_wbusy) crf[ac_crf_waddr[1:0]] <= ac_crf_wdata;
  end

  // DMA model: ready pattern plus one wr_done per accepted write command.
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      done_issued = acc_wr;
      wr_done = 1'b0;
    end else begin
      rd_cmd_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_cmd_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done_issued < acc_wr) begin
        wr_done = 1'b1;
        done_issued++;
      end else begin
        wr_done = 1'b0;
      end
    end
  end

  // Monitor: every handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      rd_exp_q.delete();
      wr_exp_q.delete();
      w_exp_q.delete();
      busy_chk_pending = 1'b0;
    end else begin
      if (busy_chk_pending) begin
        chk("busy_fall", ac_busy, 1'b0);
        busy_chk_pending = 1'b0;
      end
      if (wr_done) run_wrd++;
      if (rd_cmd_valid && rd_cmd_ready) begin
        run_rd++;
        if (rd_exp_q.size() > 0) chk("rd_addr", rd_cmd_addr, rd_exp_q.pop_front());
        else chk("rd_extra", run_rd, NRD);
      end
      if (wr_cmd_valid && wr_cmd_ready) begin
        run_wr++;
        acc_wr++;
        if (wr_exp_q.size() > 0) chk("wr_addr", wr_cmd_addr, wr_exp_q.pop_front());
        else chk("wr_extra", run_wr, NWR);
      end
      if (ac_crf_wrt && !crf_ac_wbusy) begin
        wr_taken_cnt++;
        if (w_exp_q.size() > 0) chk("crf_wr", {ac_crf_waddr, ac_crf_wdata}, w_exp_q.pop_front());
        else chk("crf_wr_extra", wr_taken_cnt, 0);
        if ({ac_crf_waddr, ac_crf_wdata} == {32'd1, 32'd0}) begin
          run_rd = 0;
          run_wr = 0;
          run_wrd = 0;
        end
        if ({ac_crf_waddr, ac_crf_wdata} == {32'd1, 32'd1}) begin
          chk("done_rd_cnt", run_rd, NRD);
          chk("done_wr_cnt", run_wrd, NWR);
          busy_chk_pending = 1'b1;
        end
      end
    end
  end

  task automatic ps_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ps_we = 1'b1; ps_addr = a; ps_data = d;
    @(posedge clk); #1;
    ps_we = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] src, input logic [31:0] dst);
    for (int i = 0; i < NRD; i++) rd_exp_q.push_back(src + 32'(i) * 32'(BURST));
    for (int i = 0; i < NWR; i++) wr_exp_q.push_back(dst + 32'(i) * 32'(BURST));
    w_exp_q.push_back({32'd1, 32'd0});
    w_exp_q.push_back({32'd0, 32'd0});
    w_exp_q.push_back({32'd1, 32'd1});
  endtask

  task automatic wait_rd_valid();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_cmd_valid) break;
    end
    chk("reach_run", rd_cmd_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (w_exp_q.size() == 0 && !ac_busy) break;
    end
    chk({tag, "_wq"}, w_exp_q.size(), 0);
    chk({tag, "_rdq"}, rd_exp_q.size(), 0);
    chk({tag, "_wrq"}, wr_exp_q.size(), 0);
    chk({tag, "_busy"}, ac_busy, 1'b0);
    chk({tag, "_valids"}, {rd_cmd_valid, wr_cmd_valid}, 2'b00);
  endtask

  task automatic start_run(input logic [31:0] src, input logic [31:0] dst);
    ps_write(2'd2, src);
    ps_write(2'd3, dst);
    push_exp(src, dst);
    ps_write(2'd0, 32'd1);
  endtask

  initial begin
    int wcnt;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {ac_crf_wrt, rd_cmd_valid, wr_cmd_valid, ac_busy}, 4'b0);
    chk("rst_data", ac_crf_waddr | ac_crf_wdata | rd_cmd_addr | wr_cmd_addr, 32'd0);
    rstn = 1'b1;

    // Basic frame, always-ready DMA
    start_run(32'h1000_0000, 32'h2000_0000);
    wait_idle("t1");

    // PS holds the register file busy while the UPENDR clear is pending
    start_run(32'h1000_0000, 32'h2000_0000);
    @(posedge clk); #1;
    busy_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_wr", {ac_crf_wrt, ac_crf_waddr, ac_crf_wdata}, {1'b1, 32'd1, 32'd0});
      @(posedge clk); #1;
    end
    busy_force = 1'b0;
    wait_idle("t2");

    // Random ready on both streams
    rand_mode = 1'b1;
    start_run(32'h3000_0040, 32'h4000_1000);
    wait_idle("t3");

    // Restart requested mid-run is honoured after DONE
    start_run(32'h0100_0000, 32'h0200_0000);
    wait_rd_valid();
    push_exp(32'h0100_0000, 32'h0200_0000);
    ps_write(2'd0, 32'd1);
    wait_idle("t5");

    // Reset during RUN
    start_run(32'h5000_0000, 32'h6000_0000);
    wait_rd_valid();
    wcnt = wr_taken_cnt;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("midrst_ctrl", {ac_crf_wrt, rd_cmd_valid, wr_cmd_valid, ac_busy}, 4'b0);
    chk("midrst_data", ac_crf_waddr | ac_crf_wdata | rd_cmd_addr | wr_cmd_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("postrst_idle", {ac_busy, ac_crf_wrt}, 2'b00);
    chk("postrst_no_wr", wr_taken_cnt, wcnt);

    // Source address wraps past 2^32
    start_run(32'hFFFF_FF00, 32'hFFFF_FE00);
    wait_idle("t4");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
